// File: rtl/switch_debounce.sv
// Switch conditioning for the processor general-purpose input port.
// Each raw switch bit is synchronized with two flops. A per-bit counter then
// qualifies it, and the debounced level is presented on sw_out. sw_chg
// strobes for one cycle whenever any sw_out bit takes a new value. gp_word
// zero-extends sw_out to the 32-bit GPIO word.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int WIDTH           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_chg,
    output logic [31:0]      gp_word
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES. It never goes past
    // DEBOUNCE_CYCLES-1, so it never wraps.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] expire;
    logic [WIDTH-1:0] out_next;

    // Two-flop synchronizer. Only sync2 feeds the qualification logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

    // Per-bit qualification. A bit expires when it has differed from sw_out
    // for DEBOUNCE_CYCLES consecutive cycles. A single agreeing cycle clears
    // the count, so short glitches never reach the output.
    always_comb begin
        differ   = sync2 ^ sw_out;
        expire   = '0;
        out_next = sw_out;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            expire[i]   = differ[i] && (cnt[i] == CNT_LAST);
            if (expire[i]) begin
                out_next[i] = sync2[i];
                cnt_next[i] = '0;
            end else if (differ[i]) begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end else begin
                cnt_next[i] = '0;
            end
        end
    end

    // Counter state. Reset discards any partial qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Debounced levels and change strobe are updated on the same edge. Bits
    // that expire together therefore share a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_out <= '0;
            sw_chg <= 1'b0;
        end else begin
            sw_out <= out_next;
            sw_chg <= |expire;
        end
    end

    // GPIO word: sw_out in the low bits, upper bits tied to zero.
    always_comb begin
        gp_word              = '0;
        gp_word[WIDTH-1:0]   = sw_out;
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce.
// Two instances are used: DEBOUNCE_CYCLES=4 and DEBOUNCE_CYCLES=1.
// Stimulus pushes {update edge, sw_out value} for every expected sw_chg
// pulse. A per-instance monitor pops an entry and compares it on each pulse.
// The monitor also flags pulses nobody expected, and expected pulses that
// never came.
module tb_switch_debounce;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  sw_in;
    logic [4:0]  sw_out;
    logic        sw_chg;
    logic [31:0] gp_word;
    logic [4:0]  sw_in1;
    logic [4:0]  sw_out1;
    logic        sw_chg1;
    logic [31:0] gp_word1;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    switch_debounce #(.DEBOUNCE_CYCLES(4), .WIDTH(5)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in),
        .sw_out(sw_out), .sw_chg(sw_chg), .gp_word(gp_word)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(1), .WIDTH(5)) dut1 (
        .clk(clk), .rst(rst), .sw_in(sw_in1),
        .sw_out(sw_out1), .sw_chg(sw_chg1), .gp_word(gp_word1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: at a falling edge, cyc is the number of rising edges seen.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect0(input int at, input logic [4:0] v);
        exp_t e;
        e.cyc = at;
        e.val = v;
        q0.push_back(e);
    endtask

    task automatic expect1(input int at, input logic [4:0] v);
        exp_t e;
        e.cyc = at;
        e.val = v;
        q1.push_back(e);
    endtask

    // Monitor for the DEBOUNCE_CYCLES=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (sw_chg === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut4_unexpected_pulse: got sw_out=%b, required no pulse (cycle %0d)", sw_out, cyc);
            end else begin
                e = q0.pop_front();
                check("dut4_pulse_cycle", cyc, e.cyc);
                check("dut4_sw_out", {27'b0, sw_out}, {27'b0, e.val});
                check("dut4_gp_word", gp_word, {27'b0, e.val});
            end
        end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            e = q0.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL dut4_missed_pulse: got no pulse, required sw_out=%b at cycle %0d", e.val, e.cyc);
        end
    end

    // Monitor for the DEBOUNCE_CYCLES=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (sw_chg1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut1_unexpected_pulse: got sw_out=%b, required no pulse (cycle %0d)", sw_out1, cyc);
            end else begin
                e = q1.pop_front();
                check("dut1_pulse_cycle", cyc, e.cyc);
                check("dut1_sw_out", {27'b0, sw_out1}, {27'b0, e.val});
                check("dut1_gp_word", gp_word1, {27'b0, e.val});
            end
        end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL dut1_missed_pulse: got no pulse, required sw_out=%b at cycle %0d", e.val, e.cyc);
        end
    end

    initial begin
        // Reset with switches already set; everything must read zero.
        rst    = 1'b1;
        sw_in  = 5'b00101;
        sw_in1 = 5'b00000;
        tick(3);
        check("reset_sw_out", {27'b0, sw_out}, 32'h0);
        check("reset_sw_chg", {31'b0, sw_chg}, 32'h0);
        check("reset_gp_word", gp_word, 32'h0);
        check("reset_dut1_sw_out", {27'b0, sw_out1}, 32'h0);
        check("reset_dut1_gp_word", gp_word1, 32'h0);

        // Held input appears 6 edges after the first edge with rst low.
        rst = 1'b0;
        expect0(cyc + 6, 5'b00101);
        tick(10);

        // Glitch of 3 cycles, 1-cycle gap, 3 more cycles: nothing qualifies.
        sw_in = 5'b01100;
        tick(3);
        sw_in = 5'b00101;
        tick(1);
        sw_in = 5'b01100;
        tick(3);
        sw_in = 5'b00101;
        tick(8);

        // Clean fall of bit 2.
        sw_in = 5'b00001;
        expect0(cyc + 6, 5'b00001);
        tick(10);

        // Bit 2 bounces high 2, low 1, then stays high.
        sw_in = 5'b00101;
        tick(2);
        sw_in = 5'b00001;
        tick(1);
        sw_in = 5'b00101;
        expect0(cyc + 6, 5'b00101);
        tick(10);

        // Bits 4 and 1 together, then bit 3 one cycle later: two adjacent pulses.
        sw_in = 5'b10111;
        expect0(cyc + 6, 5'b10111);
        tick(1);
        sw_in = 5'b11111;
        expect0(cyc + 6, 5'b11111);
        tick(10);

        // Reset while bit 0's counter is at 2.
        sw_in = 5'b11110;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("midreset_sw_out", {27'b0, sw_out}, 32'h0);
        check("midreset_sw_chg", {31'b0, sw_chg}, 32'h0);
        check("midreset_gp_word", gp_word, 32'h0);
        rst = 1'b0;
        expect0(cyc + 6, 5'b11110);
        tick(10);

        // DEBOUNCE_CYCLES=1: toggle every cycle, output follows 3 edges later.
        for (int k = 0; k < 8; k++) begin
            sw_in1 = (k % 2 == 0) ? 5'b00001 : 5'b00000;
            expect1(cyc + 3, sw_in1);
            tick(1);
        end
        tick(8);

        check("dut4_queue_drained", q0.size(), 32'd0);
        check("dut1_queue_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
